conv_stream_tx: RTL and testbench

CONV_STREAM_TX -- requirements
Module: conv_stream_tx

---
 rtl/conv_stream_tx.sv | 194 +++++++++++++++++++
 tb/tb_conv_stream_tx.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_stream_tx.sv
// conv_stream_tx: serializes accepted 4-pixel groups (p0 first) onto an 8-bit
// stream for the pooling stage, with a capture strobe on the last beat, an
// optional idle gap after each group and a wrapping completed-group counter.
// Build option: `define SKID_BUF_EN adds a one-group holding register so the
// next group can be accepted while the current one streams.
module conv_stream_tx #(
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            grp_valid,
  output logic            grp_ready,
  input  logic [3:0][7:0] grp_data,
  output logic [7:0]      conv_result,
  output logic            en,
  output logic            busy,
  output logic [15:0]     grp_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  // Gap counter load value: counts down to zero, so GAP_CYCLES cycles in GAP.
  localparam logic [3:0] GAP_LAST = (GAP_CYCLES == 32'd0) ? 4'd0 : 4'(GAP_CYCLES - 32'd1);

  state_e          state_q, state_d;
  logic [1:0]      beat_q, beat_d;
  logic [3:0]      gap_q, gap_d;
  logic [3:0][7:0] data_q, data_d;
  logic [7:0]      out_q, out_d;
  logic            en_q, en_d;
  logic            busy_q, busy_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            run_q;
  logic            accept_s;
  logic            finish_s;
  logic            start_s;
  logic [3:0][7:0] start_data_s;
`ifdef SKID_BUF_EN
  logic [3:0][7:0] hold_q, hold_d;
  logic            hold_v_q, hold_v_d;
`endif

  // run_q keeps grp_ready low until the first clock edge after reset release.
`ifdef SKID_BUF_EN
  assign grp_ready = run_q & ~hold_v_q;
`else
  assign grp_ready = run_q & (state_q == S_IDLE);
`endif

  assign accept_s    = grp_valid & grp_ready;
  assign conv_result = out_q;
  assign en          = en_q;
  assign busy        = busy_q;
  assign grp_count   = cnt_q;

  // Next-state, next-output and holding-register logic.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    gap_d        = gap_q;
    data_d       = data_q;
    out_d        = 8'h00;
    en_d         = 1'b0;
    cnt_d        = cnt_q;
    finish_s     = 1'b0;
    start_s      = 1'b0;
    start_data_s = grp_data;
`ifdef SKID_BUF_EN
    hold_d       = hold_q;
    hold_v_d     = hold_v_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          start_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (beat_q == 2'd3) begin
          if (GAP_CYCLES == 32'd0) begin
            finish_s = 1'b1;
          end else begin
            state_d = S_GAP;
            gap_d   = GAP_LAST;
          end
        end else begin
          beat_d = beat_q + 2'd1;
          out_d  = data_q[beat_d];
          en_d   = (beat_d == 2'd3);
        end
      end
      S_GAP: begin
        if (gap_q == 4'd0) begin
          finish_s = 1'b1;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // End of a group (after its gap): chain straight into a pending group.
    if (finish_s) begin
      state_d = S_IDLE;
`ifdef SKID_BUF_EN
      if (hold_v_q) begin
        start_s      = 1'b1;
        start_data_s = hold_q;
        hold_v_d     = 1'b0;
      end else if (accept_s) begin
        start_s = 1'b1;
      end else begin
        hold_v_d = 1'b0;
      end
`endif
    end else begin
      finish_s = 1'b0;
    end

`ifdef SKID_BUF_EN
    // A group arriving mid-stream parks in the holding register; when it
    // arrives on the finishing edge with the holder empty it starts directly.
    if (accept_s && (state_q != S_IDLE) && !finish_s) begin
      hold_d   = grp_data;
      hold_v_d = 1'b1;
    end else begin
      hold_d = hold_d;
    end
`endif

    if (start_s) begin
      state_d = S_SEND;
      beat_d  = 2'd0;
      data_d  = start_data_s;
      out_d   = start_data_s[0];
    end else begin
      data_d = data_d;
    end

    if (en_d) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end

`ifdef SKID_BUF_EN
    busy_d = (state_d != S_IDLE) | hold_v_d;
`else
    busy_d = (state_d != S_IDLE);
`endif
  end

  // State and registered outputs; reset discards any group in flight or held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      beat_q   <= 2'd0;
      gap_q    <= 4'd0;
      data_q   <= '0;
      out_q    <= 8'h00;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= 16'd0;
      run_q    <= 1'b0;
`ifdef SKID_BUF_EN
      hold_q   <= '0;
      hold_v_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      gap_q    <= gap_d;
      data_q   <= data_d;
      out_q    <= out_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      run_q    <= 1'b1;
`ifdef SKID_BUF_EN
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
`endif
    end
  end

endmodule

// File: tb/tb_conv_stream_tx.sv
// Self-checking bench for conv_stream_tx: vector table for single groups, a
// scoreboard fed at acceptance and checked at each en strobe, and directed
// sequences for back-to-back, gap, mid-group reset and counter wrap.
`timescale 1ns/1ps
module tb_conv_stream_tx;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            grp_valid;
  logic            grp_ready;
  logic [3:0][7:0] grp_data;
  logic [7:0]      conv_result;
  logic            en;
  logic            busy;
  logic [15:0]     grp_count;

  logic            v2;
  logic            rdy2;
  logic [3:0][7:0] d2;
  logic [7:0]      res2;
  logic            en2;
  logic            busy2;
  logic [15:0]     cnt2;

  int          checks = 0;
  int          failures = 0;
  int          en_seen = 0;
  logic [15:0] exp_count;
  logic [7:0]  sb_q[$];
  int          en_cyc_q[$];
  logic [7:0]  sh0, sh1, sh2;
  logic [7:0]  e0, e1, e2, e3;

  typedef struct {
    logic [31:0] grp;        // {p3,p2,p1,p0}
    logic [31:0] exp_beats;  // stream order {beat0,beat1,beat2,beat3}
    logic [3:0]  exp_en;     // bit k = en during beat k
    logic        scramble;
  } vec_t;
  vec_t vecs[4];

  always #5 clk = ~clk;

  conv_stream_tx dut (
    .clk(clk), .rst_n(rst_n), .grp_valid(grp_valid), .grp_ready(grp_ready),
    .grp_data(grp_data), .conv_result(conv_result), .en(en), .busy(busy),
    .grp_count(grp_count)
  );

  conv_stream_tx #(.GAP_CYCLES(2)) dut_gap (
    .clk(clk), .rst_n(rst_n), .grp_valid(v2), .grp_ready(rdy2),
    .grp_data(d2), .conv_result(res2), .en(en2), .busy(busy2),
    .grp_count(cnt2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard push: every accepted group's pixels in stream order.
  always @(posedge clk) begin
    if (rst_n && grp_valid && grp_ready) begin
      for (int k = 0; k < 4; k++) sb_q.push_back(grp_data[k]);
    end
  end

  // Reset aborts whatever was in flight.
  always @(negedge rst_n) sb_q.delete();

  // Downstream model: 3-deep shift plus live pixel, captured on en.
  always @(negedge clk) begin
    if (rst_n) begin
      if (en) begin
        en_seen++;
        if (sb_q.size() < 4) begin
          chk("sb_underflow", sb_q.size(), 32'd4);
        end else begin
          e0 = sb_q.pop_front();
          e1 = sb_q.pop_front();
          e2 = sb_q.pop_front();
          e3 = sb_q.pop_front();
          chk("sb_group", {sh2, sh1, sh0, conv_result}, {e0, e1, e2, e3});
        end
      end
      sh2 = sh1;
      sh1 = sh0;
      sh0 = conv_result;
    end
  end

  // Apply one table vector and compare beat by beat; caller is at a negedge.
  task automatic run_vec(input vec_t v);
    int budget;
    budget = 0;
    while (busy && budget < 64) begin
      @(negedge clk);
      budget++;
    end
    chk("vec_idle_wait", busy, 32'd0);
    grp_valid = 1'b1;
    grp_data  = v.grp;
    @(posedge clk);
    exp_count = exp_count + 16'd1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) grp_valid = 1'b0;
      chk("vec_beat", conv_result, v.exp_beats[31 - 8*k -: 8]);
      chk("vec_en", en, v.exp_en[k]);
      if (v.scramble) grp_data = $urandom;
    end
    chk("vec_count", grp_count, exp_count);
    @(negedge clk);
    chk("vec_after_result", conv_result, 32'd0);
    chk("vec_after_en", en, 32'd0);
  endtask

  // Continuous grp_valid on the main DUT for n groups; records en cycles.
  task automatic stream0(input int n, input int max_cyc);
    int   idx;
    logic acc;
    idx = 0;
    en_cyc_q.delete();
    grp_valid = 1'b1;
    grp_data  = $urandom;
    for (int c = 0; c < max_cyc && (idx < n || busy); c++) begin
      acc = grp_valid && grp_ready;
      @(posedge clk);
      @(negedge clk);
      if (en && n < 16) en_cyc_q.push_back(c + 1);
      if (acc) begin
        idx++;
        exp_count = exp_count + 16'd1;
        if (idx < n) grp_data = $urandom;
        else grp_valid = 1'b0;
      end
    end
    chk("stream_accepts", idx, n);
    chk("stream_drained", busy, 32'd0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = 16'd0;
    @(negedge clk);
  endtask

  initial begin
    #(64'd50_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int          en_before;
    int          en_total;
    int          second_en;
    logic        acc;
    int          idx;
    logic [7:0]  r2_hist [0:24];
    logic        e2_hist [0:24];
    int          exp31 [3];

    vecs[0] = '{grp: 32'h8003FE05, exp_beats: 32'h05FE0380, exp_en: 4'b1000, scramble: 1'b0};
    vecs[1] = '{grp: 32'h01807FFF, exp_beats: 32'hFF7F8001, exp_en: 4'b1000, scramble: 1'b1};
    vecs[2] = '{grp: 32'h3CC355AA, exp_beats: 32'hAA55C33C, exp_en: 4'b1000, scramble: 1'b1};
    vecs[3] = '{grp: 32'h00000000, exp_beats: 32'h00000000, exp_en: 4'b1000, scramble: 1'b1};
`ifdef SKID_BUF_EN
    exp31 = '{4, 8, 12};
`else
    exp31 = '{4, 9, 14};
`endif

    rst_n = 1'b0;
    grp_valid = 1'b0;
    grp_data = 32'h0;
    v2 = 1'b0;
    d2 = 32'h0;
    exp_count = 16'd0;
    sh0 = 8'h00; sh1 = 8'h00; sh2 = 8'h00;

    // Reset state
    #1;
    chk("rst_result", conv_result, 32'd0);
    chk("rst_en", en, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_count", grp_count, 32'd0);
    chk("rst_ready", grp_ready, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", grp_ready, 32'd0);
    @(negedge clk);
    chk("ready_after_edge", grp_ready, 32'd1);

    // Table-driven single groups
    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Three groups back-to-back, GAP_CYCLES = 0
    stream0(3, 40);
    chk("b2b_en_count", en_cyc_q.size(), 32'd3);
    for (int i = 0; i < 3 && i < en_cyc_q.size(); i++) chk("b2b_en_cycle", en_cyc_q[i], exp31[i]);
    chk("b2b_count", grp_count, exp_count);

    // GAP_CYCLES = 2 instance, continuous valid
    v2 = 1'b1;
    d2 = 32'hA4A3A2A1;
    idx = 0;
    for (int c = 0; c < 24; c++) begin
      acc = v2 && rdy2;
      @(posedge clk);
      @(negedge clk);
      r2_hist[c + 1] = res2;
      e2_hist[c + 1] = en2;
      if (acc) begin
        idx++;
        if (idx < 2) d2 = 32'hB4B3B2B1;
        else v2 = 1'b0;
      end
    end
`ifdef SKID_BUF_EN
    second_en = 10;
`else
    second_en = 11;
`endif
    en_total = 0;
    for (int c = 1; c <= 24; c++) en_total += int'(e2_hist[c]);
    chk("gap_first_en", e2_hist[4], 32'd1);
    chk("gap_first_p3", r2_hist[4], 32'hA4);
    chk("gap_c1_result", r2_hist[5], 32'd0);
    chk("gap_c1_en", e2_hist[5], 32'd0);
    chk("gap_c2_result", r2_hist[6], 32'd0);
    chk("gap_c2_en", e2_hist[6], 32'd0);
    chk("gap_second_p0", r2_hist[second_en - 3], 32'hB1);
    chk("gap_second_en", e2_hist[second_en], 32'd1);
    chk("gap_second_p3", r2_hist[second_en], 32'hB4);
    chk("gap_en_total", en_total, 32'd2);
    chk("gap_count", cnt2, 32'd2);

    // Reset pulsed during beat 2
    grp_valid = 1'b1;
    grp_data  = 32'h44332211;
    @(posedge clk);
    @(negedge clk);
    grp_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_beat2", conv_result, 32'h33);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_result", conv_result, 32'd0);
    chk("abort_en", en, 32'd0);
    chk("abort_busy", busy, 32'd0);
    chk("abort_count", grp_count, 32'd0);
    chk("abort_ready", grp_ready, 32'd0);
    exp_count = 16'd0;
    en_before = en_seen;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_ready_release", grp_ready, 32'd0);
    repeat (6) @(negedge clk);
    chk("abort_no_en", en_seen - en_before, 32'd0);
    chk("abort_count_after", grp_count, 32'd0);
    run_vec(vecs[0]);

    // Counter wrap after 65536 groups
    pulse_reset();
    stream0(65535, 6 * 65535 + 64);
    chk("wrap_ffff", grp_count, 32'hFFFF);
    run_vec(vecs[2]);
    chk("wrap_zero", grp_count, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
